// File: rtl/image_load_avalon_master_if.sv
// ---------------------------------------------------------------------------
// image_load_avalon_master_if
// Bundles the two data paths of the frame playback master:
//   - Avalon-MM read side : avm_address, avm_read, avm_readdata,
//                           avm_waitrequest, avm_readdatavalid
//   - Avalon-ST video out : dout_data, dout_valid, dout_ready,
//                           dout_startofpacket, dout_endofpacket
// The master modport is the playback engine; the slave modport is the
// environment (memory slave plus stream sink).
// ---------------------------------------------------------------------------
interface image_load_avalon_master_if #(
    parameter int DATA_W = 16
) ();
    logic [31:0]       avm_address;
    logic              avm_read;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;
    logic              avm_readdatavalid;

    logic [DATA_W-1:0] dout_data;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_startofpacket;
    logic              dout_endofpacket;

    modport master (
        output avm_address, avm_read,
        input  avm_readdata, avm_waitrequest, avm_readdatavalid,
        output dout_data, dout_valid, dout_startofpacket, dout_endofpacket,
        input  dout_ready
    );

    modport slave (
        input  avm_address, avm_read,
        output avm_readdata, avm_waitrequest, avm_readdatavalid,
        input  dout_data, dout_valid, dout_startofpacket, dout_endofpacket,
        output dout_ready
    );
endinterface

// File: rtl/image_load_avalon_master.sv
// ---------------------------------------------------------------------------
// image_load_avalon_master
// Plays back N stored video frames laid out back-to-back in memory from a
// base address. Words are fetched with pipelined Avalon-MM reads into a
// show-ahead prefetch FIFO and emitted as SOP/EOP framed Avalon-ST packets.
// Reads are credit limited (outstanding + buffered < depth), so stream
// backpressure can never overflow the FIFO.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (master)      Avalon-MM read port and Avalon-ST output stream
//   sig_en            load configuration (honoured only while idle)
//   sig_address       frame base byte address
//   sig_frame_words   words per frame
//   sig_image_cnt     number of frames to play
//   sig_busy          high whenever the engine is not idle
// ---------------------------------------------------------------------------

// Checker: a push into a full prefetch FIFO means the credit rule broke.
module image_load_avalon_master_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic full
);
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

module image_load_avalon_master #(
    parameter int AVM_WIDTH_LOG  = 4,
    parameter int STORE_WIDTH    = 4,
    parameter int WORDS_WIDTH    = 24,
    parameter int FIFO_DEPTH_LOG = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    image_load_avalon_master_if.master   bus,
    input  logic                         sig_en,
    input  logic [31:0]                  sig_address,
    input  logic [WORDS_WIDTH-1:0]       sig_frame_words,
    input  logic [STORE_WIDTH-1:0]       sig_image_cnt,
    output logic                         sig_busy
);
    localparam int DATA_W = 1 << AVM_WIDTH_LOG;
    localparam int DEPTH  = 1 << FIFO_DEPTH_LOG;
    localparam int CNT_W  = FIFO_DEPTH_LOG + 1;
    localparam logic [31:0]      ADDR_STEP = 32'(1 << (AVM_WIDTH_LOG - 3));
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_MIN   = 2'd3
    } state_e;

    state_e                   state_q;
    logic [31:0]              base_q;
    logic [WORDS_WIDTH-1:0]   words_q;
    logic [STORE_WIDTH-1:0]   image_cnt_q;
    logic [31:0]              addr_cnt_q;
    logic [WORDS_WIDTH-1:0]   req_cnt_q;
    logic [WORDS_WIDTH-1:0]   out_cnt_q;
    logic [CNT_W-1:0]         outstanding_q;
    logic [CNT_W-1:0]         outstanding_d;

    logic [DATA_W-1:0]         fifo_mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] wr_ptr_q;
    logic [FIFO_DEPTH_LOG-1:0] rd_ptr_q;
    logic [CNT_W-1:0]          fifo_count_q;
    logic [CNT_W-1:0]          fifo_count_d;

    logic [CNT_W-1:0]       pending_s;
    logic                   fifo_empty_s;
    logic                   fifo_full_s;
    logic                   rd_req_s;
    logic                   accept_s;
    logic                   push_s;
    logic                   pop_s;
    logic [WORDS_WIDTH-1:0] words_m1_s;
    logic                   eop_s;
    logic                   last_req_s;

    assign pending_s    = outstanding_q + fifo_count_q;
    assign fifo_empty_s = (fifo_count_q == {CNT_W{1'b0}});
    assign fifo_full_s  = (fifo_count_q == DEPTH_C);
    assign rd_req_s     = (state_q == ST_LOAD) && (req_cnt_q < words_q) && (pending_s < DEPTH_C);
    assign accept_s     = rd_req_s && !bus.avm_waitrequest;
    // Returns with nothing outstanding belong to reads issued before a reset.
    assign push_s       = bus.avm_readdatavalid && (outstanding_q != {CNT_W{1'b0}});
    assign pop_s        = !fifo_empty_s && bus.dout_ready;
    assign words_m1_s   = words_q - WORDS_WIDTH'(1);
    assign eop_s        = (out_cnt_q == words_m1_s);
    assign last_req_s   = ((req_cnt_q + WORDS_WIDTH'(1)) == words_q);

    assign bus.avm_read           = rd_req_s;
    assign bus.avm_address        = base_q + addr_cnt_q;
    assign bus.dout_data          = fifo_mem_q[rd_ptr_q];
    assign bus.dout_valid         = !fifo_empty_s;
    assign bus.dout_startofpacket = !fifo_empty_s && (out_cnt_q == {WORDS_WIDTH{1'b0}});
    assign bus.dout_endofpacket   = !fifo_empty_s && eop_s;
    assign sig_busy               = (state_q != ST_IDLE);

    // Outstanding-read and FIFO occupancy next values; simultaneous +/- cancel.
    always_comb begin
        outstanding_d = outstanding_q;
        fifo_count_d  = fifo_count_q;
        case ({accept_s, push_s})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
        case ({push_s, pop_s})
            2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // Prefetch FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_q[wr_ptr_q] <= bus.avm_readdata;
                wr_ptr_q             <= wr_ptr_q + FIFO_DEPTH_LOG'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_LOG'(1);
            end
            fifo_count_q <= fifo_count_d;
        end
    end

    // Playback FSM with configuration, address, request and output counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            words_q       <= '0;
            image_cnt_q   <= '0;
            addr_cnt_q    <= '0;
            req_cnt_q     <= '0;
            out_cnt_q     <= '0;
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (pop_s) begin
                out_cnt_q <= eop_s ? {WORDS_WIDTH{1'b0}} : out_cnt_q + WORDS_WIDTH'(1);
            end
            if (accept_s) begin
                req_cnt_q  <= req_cnt_q + WORDS_WIDTH'(1);
                addr_cnt_q <= addr_cnt_q + ADDR_STEP;
            end
            case (state_q)
                ST_IDLE: begin
                    // The address offset only rewinds once the whole job is done,
                    // so the frames of one job sit back to back in memory.
                    if (image_cnt_q == {STORE_WIDTH{1'b0}}) begin
                        addr_cnt_q <= '0;
                    end
                    if (sig_en) begin
                        base_q      <= sig_address;
                        words_q     <= sig_frame_words;
                        image_cnt_q <= sig_image_cnt;
                    end else if (image_cnt_q != {STORE_WIDTH{1'b0}}) begin
                        if (words_q != {WORDS_WIDTH{1'b0}}) begin
                            state_q   <= ST_LOAD;
                            req_cnt_q <= '0;
                        end else begin
                            // Empty frames: drop the job instead of spinning.
                            image_cnt_q <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept_s && last_req_s) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop_s && eop_s) begin
                        state_q <= ST_MIN;
                    end
                end
                ST_MIN: begin
                    image_cnt_q <= image_cnt_q - STORE_WIDTH'(1);
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    image_load_avalon_master_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .full  (fifo_full_s)
    );
endmodule

// File: doc/image_load_avalon_master.md
Name: image_load_avalon_master

Overview:
- Avalon-MM read master that fetches stored video frames from memory and emits them as an Avalon-ST video packet stream (startofpacket/endofpacket framed).
- Downstream companion of the image store write master: plays back N frames laid out back-to-back from a base address.
- Pipelined reads use readdatavalid, with a credit-limited prefetch FIFO so backpressure on the stream never overflows.

Parameters:
- AVM_WIDTH_LOG, 4, log2 of data bus width in bits; bus = 1<<AVM_WIDTH_LOG bits, address step = 1<<(AVM_WIDTH_LOG-3) bytes.
- STORE_WIDTH, 4, width of frame-count field.
- WORDS_WIDTH, 24, width of words-per-frame field.
- FIFO_DEPTH_LOG, 3, log2 of prefetch FIFO depth (default 8 entries).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- avm_address  out  32  byte address = base_reg + addr_cnt
- avm_read  out  1  read request
- avm_readdata  in  1<<AVM_WIDTH_LOG  read data
- avm_waitrequest  in  1  slave stall
- avm_readdatavalid  in  1  read data valid
- dout_data  out  1<<AVM_WIDTH_LOG  stream pixel word
- dout_valid  out  1  stream valid
- dout_ready  in  1  stream ready
- dout_startofpacket  out  1  first word of frame
- dout_endofpacket  out  1  last word of frame
- sig_en  in  1  load configuration (honoured only in IDLE)
- sig_address  in  32  frame base byte address
- sig_frame_words  in  WORDS_WIDTH  words per frame
- sig_image_cnt  in  STORE_WIDTH  frames to play
- sig_busy  out  1  high when state != IDLE

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. All registers clear. state=IDLE; avm_read=0, dout_valid=0, dout_startofpacket=0, dout_endofpacket=0, sig_busy=0, avm_address=0. FIFO empty, all counters zero. Reset mid-frame aborts immediately, with no partial EOP. readdatavalid for reads issued before reset is ignored.
- Config: in IDLE with sig_en=1, latch base_reg, words_reg and image_cnt on that edge. sig_en outside IDLE is ignored.
- FSM states: IDLE, LOAD, DRAIN, MIN.
  - IDLE->LOAD when image_cnt!=0 and words_reg!=0.
  - If image_cnt!=0 and words_reg==0: clear image_cnt and stay in IDLE.
  - In IDLE with image_cnt==0: addr_cnt cleared to 0.
  - LOAD->DRAIN on the cycle the last read of the frame is accepted (req_cnt reaches words_reg).
  - DRAIN->MIN on the stream handshake (dout_valid&dout_ready) of the EOP word.
  - MIN: image_cnt decrements by 1, then go to IDLE. Any remaining frames restart LOAD 2 cycles later.
  - addr_cnt is NOT cleared between frames, so consecutive frames occupy consecutive addresses.
- Read issue:
  - avm_read = (state==LOAD) & (req_cnt<words_reg) & (pending<DEPTH), where pending = outstanding + fifo_count.
  - A read is accepted on avm_read&~avm_waitrequest. Acceptance increments req_cnt and outstanding, and advances addr_cnt by the step.
  - avm_read and avm_address are held stable while waitrequest=1.
  - First avm_read asserts in the first LOAD cycle, i.e. 1 cycle after the IDLE->LOAD edge.
- Read return:
  - Each readdatavalid pushes avm_readdata into the FIFO and decrements outstanding.
  - The credit rule guarantees space; a push while full is a design error and is flagged by an assertion.
  - A simultaneous accept and return leaves outstanding unchanged.
- Stream output:
  - Show-ahead FIFO: dout_data = FIFO head; dout_valid = ~empty.
  - Pop on dout_valid&dout_ready. Push and pop in the same cycle keeps fifo_count unchanged.
  - dout_startofpacket = dout_valid & (out_cnt==0); dout_endofpacket = dout_valid & (out_cnt==words_reg-1).
  - out_cnt increments per pop and clears after the EOP pop. Data, SOP and EOP are held while ready=0.
  - words_reg==1: SOP and EOP are asserted together on a single word.
- Arithmetic: all counters wrap modulo their width. addr_cnt is 32-bit and wraps silently. out_cnt and req_cnt are WORDS_WIDTH bits wide. pending is FIFO_DEPTH_LOG+1 bits wide.

Test Plan:
- Basic frame: base=0x1000, words=4, cnt=1, no stalls, readdatavalid 2 cycles after accept -> reads at 0x1000/0x1002/0x1004/0x1006; stream D0..D3 with SOP on D0 and EOP on D3; sig_busy falls 2 cycles after EOP handshake.
- Multi-frame: words=3, cnt=2 -> 6 reads at 0x0..0xA, consecutive; two packets, each with SOP/EOP; image_cnt 2->1->0; next sig_en start reissues from base (addr_cnt=0).
- Backpressure: words=20, dout_ready=0 for 30 cycles -> exactly 8 reads outstanding+buffered; avm_read low until a pop occurs; no data lost; the order of the 20 words is preserved.
- Waitrequest: waitrequest high 3 cycles on the 2nd read -> avm_read/avm_address held at 0x1002 for those cycles; req_cnt advances only on accept.
- Corner sizes: words=1 -> single word with SOP=EOP=1. words=0 with cnt=5 -> no reads issued, image_cnt cleared, sig_busy stays 0.
- Reset mid-frame: rst_n low after 5 of 10 words -> all outputs 0 immediately; next start with words=10 yields a clean SOP with no stale FIFO data.
